// File: rtl/compare_sched.sv
// Shared 32-bit condition comparator for the branch unit (port 0) and trap unit (port 1).
// Port 1 has priority; a saturating wait counter bounds how long port 0 can be starved.
module compare_sched #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush0,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_cond0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_cond1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_result,
  output logic             rsp_err
);

  localparam int            WW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  localparam logic [2:0] COND_EQ  = 3'b000;
  localparam logic [2:0] COND_NE  = 3'b001;
  localparam logic [2:0] COND_GZ  = 3'b010;
  localparam logic [2:0] COND_LZ  = 3'b011;
  localparam logic [2:0] COND_GEZ = 3'b100;
  localparam logic [2:0] COND_LEZ = 3'b101;

  logic [WW-1:0]    wait0;
  logic             prio0;
  logic             grant0;
  logic             grant1;

  logic             s1_valid;
  logic             s1_id;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_cond;

  logic             cmp_res;
  logic             cmp_err;
  logic             a_neg;
  logic             a_zero;

  assign prio0  = (wait0 >= LIMIT);
  // Port 1 loses only when port 0 actually takes the slot, so a starved-but-idle port 0 never blocks it.
  assign grant0 = !stall && req_valid0 && !flush0 && (prio0 || !req_valid1);
  assign grant1 = !stall && req_valid1 && !grant0;

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait0 <= '0;
    end else if (flush0) begin
      wait0 <= '0;
    end else if (stall) begin
      wait0 <= wait0;
    end else if (!req_valid0 || grant0) begin
      wait0 <= '0;
    end else if (wait0 < LIMIT) begin
      wait0 <= wait0 + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cond  <= '0;
    end else if (!stall) begin
      s1_valid <= grant0 || grant1;
      if (grant0 || grant1) begin
        s1_id   <= grant1;
        s1_a    <= grant1 ? req_a1    : req_a0;
        s1_b    <= grant1 ? req_b1    : req_b0;
        s1_cond <= grant1 ? req_cond1 : req_cond0;
      end
    end else if (flush0 && !s1_id) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    cmp_res = 1'b0;
    cmp_err = 1'b0;
    a_neg   = s1_a[WIDTH-1];
    a_zero  = (s1_a == '0);
    case (s1_cond)
      COND_EQ:  cmp_res = (s1_a == s1_b);
      COND_NE:  cmp_res = (s1_a != s1_b);
      COND_GZ:  cmp_res = !a_neg && !a_zero;
      COND_LZ:  cmp_res = a_neg;
      COND_GEZ: cmp_res = !a_neg;
      COND_LEZ: cmp_res = a_neg || a_zero;
      default:  cmp_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= s1_valid && !(flush0 && !s1_id);
      if (s1_valid) begin
        rsp_id     <= s1_id;
        rsp_result <= cmp_res;
        rsp_err    <= cmp_err;
      end
    end else if (flush0 && !rsp_id) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_compare_sched.sv
// Directed bench for compare_sched: latency, signed conditions, arbitration fairness,
// flush, stall hold, reserved codes and mid-stream reset.
module tb_compare_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        flush0;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  c0, c1;
  logic        rsp_valid, rsp_id, rsp_result, rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  compare_sched #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .flush0     (flush0),
    .req_valid0 (valid0),
    .req_ready0 (ready0),
    .req_a0     (a0),
    .req_b0     (b0),
    .req_cond0  (c0),
    .req_valid1 (valid1),
    .req_ready1 (ready1),
    .req_a1     (a1),
    .req_b1     (b1),
    .req_cond1  (c1),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic single(input string tag, input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cond, input bit exp_res, input bit exp_err);
    if (port) begin
      valid1 = 1'b1; a1 = a; b1 = b; c1 = cond;
    end else begin
      valid0 = 1'b1; a0 = a; b0 = b; c0 = cond;
    end
    #1;
    chk({tag, "_rdy"}, port ? ready1 : ready0, 1);
    step();
    valid0 = 1'b0;
    valid1 = 1'b0;
    chk({tag, "_lat"}, rsp_valid, 0);
    step();
    chk({tag, "_vld"}, rsp_valid,  1);
    chk({tag, "_id"},  rsp_id,     port);
    chk({tag, "_res"}, rsp_result, exp_res);
    chk({tag, "_err"}, rsp_err,    exp_err);
    step();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_g [8];
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    reset_n = 1'b0;
    stall = 1'b0; flush0 = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    #1;
    chk("rst_vld", rsp_valid,  0);
    chk("rst_id",  rsp_id,     0);
    chk("rst_res", rsp_result, 0);
    chk("rst_err", rsp_err,    0);
    valid0 = 1'b1;
    #1;
    chk("rst_rdy0_comb", ready0, 1);
    valid0 = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // T1 / T2 single operations
    single("t1_eq",    1'b0, 32'd5,          32'd5, 3'b000, 1'b1, 1'b0);
    single("t2_gz",    1'b1, 32'h8000_0000,  32'd0, 3'b010, 1'b0, 1'b0);
    single("t2_lz",    1'b1, 32'h8000_0000,  32'd0, 3'b011, 1'b1, 1'b0);
    single("t2_lez0",  1'b1, 32'd0,          32'd0, 3'b101, 1'b1, 1'b0);
    single("t2_gez",   1'b1, 32'h7fff_ffff,  32'd0, 3'b100, 1'b1, 1'b0);
    single("t2_ne",    1'b0, 32'd6,          32'd7, 3'b001, 1'b1, 1'b0);

    // T3 contention: port 0 EQ (true), port 1 NE (false)
    valid0 = 1'b1; a0 = 32'd7; b0 = 32'd7; c0 = 3'b000;
    valid1 = 1'b1; a1 = 32'd7; b1 = 32'd7; c1 = 3'b001;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t3_rdy1_%0d", i), ready1, exp_g[i]);
      chk($sformatf("t3_rdy0_%0d", i), ready0, !exp_g[i]);
      step();
      if (i >= 1) begin
        chk($sformatf("t3_id_%0d", i - 1),  rsp_id,     exp_g[i-1]);
        chk($sformatf("t3_res_%0d", i - 1), rsp_result, !exp_g[i-1]);
      end
    end
    valid0 = 1'b0; valid1 = 1'b0;
    step();
    chk("t3_id_5", rsp_id, exp_g[5]);
    step();
    chk("t3_drain", rsp_valid, 0);

    // T4 flush: port-0 op in S1, port-1 op granted in flush cycle
    valid0 = 1'b1; a0 = 32'd3; b0 = 32'd3; c0 = 3'b000;
    #1;
    chk("t4_rdy0_pre", ready0, 1);
    step();
    valid1 = 1'b1; a1 = 32'd9; b1 = 32'd9; c1 = 3'b000;
    flush0 = 1'b1;
    #1;
    chk("t4_rdy0_fl", ready0, 0);
    chk("t4_rdy1_fl", ready1, 1);
    step();
    flush0 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    chk("t4_no_id0", rsp_valid, 0);
    chk("t4_wait0",  dut.wait0, 0);
    step();
    chk("t4_vld1", rsp_valid,  1);
    chk("t4_id1",  rsp_id,     1);
    chk("t4_res1", rsp_result, 1);
    step();

    // T5 stall
    valid1 = 1'b1; a1 = 32'd1; b1 = 32'd1; c1 = 3'b000;
    step();
    c1 = 3'b001;
    step();
    chk("t5_pre_vld", rsp_valid, 1);
    stall = 1'b1;
    valid0 = 1'b1; a0 = 32'd2; b0 = 32'd2; c0 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_rdy0_%0d", i), ready0, 0);
      chk($sformatf("t5_rdy1_%0d", i), ready1, 0);
      step();
      chk($sformatf("t5_vld_%0d", i), rsp_valid,  1);
      chk($sformatf("t5_res_%0d", i), rsp_result, 1);
      chk($sformatf("t5_id_%0d", i),  rsp_id,     1);
    end
    stall = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    step();
    chk("t5_next_vld", rsp_valid,  1);
    chk("t5_next_res", rsp_result, 0);
    step();
    chk("t5_drain", rsp_valid, 0);

    // T6 reserved code, then reset mid-stream
    single("t6_rsv", 1'b0, 32'd1, 32'd2, 3'b111, 1'b0, 1'b1);
    single("t6_rsv6", 1'b1, 32'd1, 32'd1, 3'b110, 1'b0, 1'b1);
    valid1 = 1'b1; a1 = 32'd4; b1 = 32'd4; c1 = 3'b000;
    step();
    step();
    chk("t6_pre_vld", rsp_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_vld", rsp_valid, 0);
    valid1 = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("t6_post_vld0", rsp_valid, 0);
    step();
    chk("t6_post_vld1", rsp_valid, 0);
    chk("t6_post_id",   rsp_id,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
